uart_instr_fetch: RTL
=====================

Name: uart_instr_fetch

Overview:
- Upstream instruction-fetch stage for the bitty core.
- Given a PC address, it requests one 16-bit instruction from the host over the shared UART and assembles it from two received bytes.
- It then presents the word to the core and branch logic with a one-cycle done pulse.
- It owns the UART TX/RX handshake only while a fetch is in flight and yields it when hold is high.

Parameters:
- CMD_FETCH, 8'h03, command byte sent ahead of the address byte.
- TIMEOUT_CYCLES, 100000, clocks allowed between progress events before a retry (FETCH_TIMEOUT_EN only).
- MAX_RETRY, 3, retries after the first attempt before the fetch is abandoned (FETCH_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a fetch; sampled in IDLE only.
- hold  in  1  core owns the UART; blocks the start of a new fetch.
- address  in  8  PC value; latched when start is accepted.
- tx_done  in  1  UART TX finished the current byte (1-cycle pulse).
- rx_done  in  1  UART RX byte valid (1-cycle pulse).
- rx_data  in  8  received byte; valid when rx_done=1.
- tx_start  out  1  1-cycle pulse to start a UART TX.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
- instruction  out  16  last fetched instruction; {high byte, low byte}.
- done  out  1  1-cycle pulse when a fetch completes or is abandoned.
- busy  out  1  high from the accepting edge until the done pulse inclusive.
- error  out  1  sticky; set on abandon, cleared when the next start is accepted.

Behaviour:
- Reset: state IDLE. tx_start, tx_data, instruction, done, busy, error, retry count and timeout counter are all 0.
- IDLE:
  - start=1 and hold=0: latch address, clear error, go to SEND_CMD; busy=1 from the next cycle.
  - start=1 and hold=1: ignored; no state change, no latch.
- SEND_CMD: tx_data=CMD_FETCH, tx_start=1 for exactly one cycle, then WAIT_CMD.
- WAIT_CMD: on tx_done, go to SEND_ADDR.
- SEND_ADDR: tx_data=latched address, tx_start=1 for one cycle, then WAIT_ADDR.
- WAIT_ADDR: on tx_done, go to RX_HI.
- RX_HI: on rx_done, store rx_data in the high-byte shadow register, then RX_LO.
- RX_LO: on rx_done, instruction <= {shadow, rx_data}, then DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- Latency: done rises the cycle after the low-byte rx_done. The minimum start-to-done with immediate UART responses is 7 cycles.
- instruction changes only on the RX_LO capture edge. It holds its old value throughout a fetch and after an abandon.
- rx_done outside RX_HI/RX_LO and tx_done outside WAIT_CMD/WAIT_ADDR are ignored; no state change.
- rx_done and tx_done asserted in the same cycle: only the event relevant to the current state is acted on.
- start while busy: ignored; no re-latch of address.
- hold while busy: no effect. The fetch runs to completion; the core must not drive the UART until done.
- The address is held in an internal register. A change on the address port mid-fetch has no effect.
- Reset mid-fetch: return to IDLE next edge. tx_start is forced low; instruction is cleared to 0.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: a timeout counter runs in WAIT_CMD, WAIT_ADDR, RX_HI and RX_LO.
  - It clears on entry to each of these states and on every accepted tx_done/rx_done.
  - Reaching TIMEOUT_CYCLES with retry count < MAX_RETRY: increment the retry count, discard the shadow byte, go to SEND_CMD and resend both bytes.
  - Reaching TIMEOUT_CYCLES with retry count = MAX_RETRY: set error, go to DONE (done pulses, instruction unchanged).
  - The retry count clears when a start is accepted.
- Undefined: no counter and no retry logic; waits indefinitely in each wait state. error is tied to 0.

Test Plan:
- Basic fetch: reset, then start with address=8'h2A.
  - Expect tx_start with tx_data=8'h03, then 8'h2A after tx_done.
  - Feed rx bytes 8'h12 then 8'h34: instruction=16'h1234, done pulses one cycle after the second rx_done, busy falls with it.
- Start with hold=1 in IDLE: no tx_start, busy stays 0. Drop hold and pulse start with address 8'h05: the fetch proceeds and sends 8'h03, 8'h05.
- Busy conditions, during a fetch to 8'h10:
  - Pulse start with address=8'h99: second TX byte is still 8'h10.
  - Spurious rx_done during WAIT_CMD: ignored; instruction is assembled only from the post-address bytes.
- Reset mid-fetch, asserted in RX_LO: next cycle IDLE, busy=0, instruction=0, no done pulse. A new fetch of 8'h01 returning 8'hAB, 8'hCD gives 16'hABCD.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=20, MAX_RETRY=2:
  - No rx after the address: 8'h03/addr is resent twice, then done with error=1 and instruction unchanged.
  - A following successful start clears error.
- Without FETCH_TIMEOUT_EN: 1000 idle cycles in RX_HI keep busy=1 with no resend; a late rx pair completes normally.

Source files
------------

// File: rtl/uart_instr_fetch.sv
// Instruction fetch over the shared UART: sends CMD_FETCH and the PC byte, then assembles a 16-bit word from two RX bytes.
// Optional retry/abandon logic is enabled with `define FETCH_TIMEOUT_EN.
module uart_instr_fetch #(
    parameter logic [7:0] CMD_FETCH = 8'h03
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRY      = 3
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic [7:0]  address,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] instruction,
    output logic        done,
    output logic        busy,
    output logic        error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND_CMD  = 3'd1;
    localparam logic [2:0] S_WAIT_CMD  = 3'd2;
    localparam logic [2:0] S_SEND_ADDR = 3'd3;
    localparam logic [2:0] S_WAIT_ADDR = 3'd4;
    localparam logic [2:0] S_RX_HI     = 3'd5;
    localparam logic [2:0] S_RX_LO     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0] state_r;
    logic [7:0] addr_r;
    logic [7:0] shadow_r;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    logic [TW-1:0] tmo_cnt_r;
    logic [RW-1:0] retry_r;
    logic          in_wait_s;
    logic          accept_s;
    logic          timeout_s;

    // Classify the current cycle: waiting, progress accepted, or timed out.
    always_comb begin
        in_wait_s = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            S_WAIT_CMD, S_WAIT_ADDR: begin
                in_wait_s = 1'b1;
                accept_s  = tx_done;
            end
            S_RX_HI, S_RX_LO: begin
                in_wait_s = 1'b1;
                accept_s  = rx_done;
            end
            default: begin
                in_wait_s = 1'b0;
                accept_s  = 1'b0;
            end
        endcase
        timeout_s = in_wait_s && !accept_s && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    end

    // Progress timer: zero outside wait states, on progress and on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (!in_wait_s || accept_s || timeout_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end
`endif

    // Fetch sequencer; every output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            addr_r      <= 8'h00;
            shadow_r    <= 8'h00;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            instruction <= 16'h0000;
            done        <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            retry_r     <= {RW{1'b0}};
`endif
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && !hold) begin
                        addr_r   <= address;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        tx_start <= 1'b1;
                        tx_data  <= CMD_FETCH;
                        state_r  <= S_SEND_CMD;
`ifdef FETCH_TIMEOUT_EN
                        retry_r  <= {RW{1'b0}};
`endif
                    end
                end
                S_SEND_CMD:  state_r <= S_WAIT_CMD;
                S_WAIT_CMD: begin
                    if (tx_done) begin
                        tx_start <= 1'b1;
                        tx_data  <= addr_r;
                        state_r  <= S_SEND_ADDR;
                    end
                end
                S_SEND_ADDR: state_r <= S_WAIT_ADDR;
                S_WAIT_ADDR: begin
                    if (tx_done) begin
                        state_r <= S_RX_HI;
                    end
                end
                S_RX_HI: begin
                    if (rx_done) begin
                        shadow_r <= rx_data;
                        state_r  <= S_RX_LO;
                    end
                end
                S_RX_LO: begin
                    if (rx_done) begin
                        instruction <= {shadow_r, rx_data};
                        done        <= 1'b1;
                        state_r     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
`ifdef FETCH_TIMEOUT_EN
            // Expiry overrides the case above: resend from the command byte or give up.
            if (timeout_s) begin
                shadow_r <= 8'h00;
                if (retry_r < RW'(MAX_RETRY)) begin
                    retry_r  <= retry_r + RW'(1);
                    tx_start <= 1'b1;
                    tx_data  <= CMD_FETCH;
                    state_r  <= S_SEND_CMD;
                end else begin
                    error    <= 1'b1;
                    done     <= 1'b1;
                    state_r  <= S_DONE;
                end
            end
`endif
        end
    end

endmodule
